// File: rtl/rf_scan_pkg.sv
// Shared encodings for the receptive-field scan sequencer.
// Global system states, scan FSM states and default frame length.
package rf_scan_pkg;

  localparam int N_RF_DEF = 16;

  typedef enum logic [1:0] {
    SYS_IDLE     = 2'b00,
    SYS_SAMPLE   = 2'b01,
    SYS_COMPLETE = 2'b10,
    SYS_UART     = 2'b11
  } sys_state_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_DAC_WR = 3'd2,
    S_SETTLE = 3'd3,
    S_SAMPLE = 3'd4,
    S_NEXT   = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } scan_state_t;

endpackage

// File: rtl/rf_scan_ctrl_timer.sv
// Saturating 10-bit wait timer shared by the DAC, settle and ADC waits.
// Clear has priority; hit compares the running count to the limit.
module rf_wait_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [9:0] i_limit,
  output logic       o_hit
);

  logic [9:0] r_cnt;

  // Count up while enabled, hold at all-ones, restart on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != 10'h3FF)) begin
      r_cnt <= r_cnt + 10'd1;
    end
  end

  assign o_hit = (r_cnt == i_limit);

endmodule

// File: rtl/rf_scan_ctrl.sv
// Receptive-field scan sequencer for the 4-channel DAC read front end.
// Per position: load field, SPI update, settle, ADC handoff, advance.
module rf_scan_ctrl
  import rf_scan_pkg::*;
#(
  parameter int N_RF       = N_RF_DEF,
  parameter int SETTLE_CYC = 100,
  parameter int DAC_TMO    = 255,
  parameter int ADC_TMO    = 1023
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            key_state,
  input  logic [1:0]      system_state,
  input  logic            frame_start,
  input  logic [4*N_RF-1:0] pattern,
  output logic [3:0]      field,
  output logic [4:0]      cnt_RF,
  output logic            dac_req,
  input  logic            dac_done,
  output logic            adc_req,
  input  logic            adc_ack,
  output logic            scan_busy,
  output logic            scan_done,
  output logic            err_tmo
);

  localparam logic [4:0] CNT_END  = 5'(N_RF);
  localparam logic [4:0] CNT_LAST = 5'(N_RF - 1);
  localparam logic [9:0] L_DAC    = 10'(DAC_TMO);
  localparam logic [9:0] L_SET    = 10'(SETTLE_CYC - 1);
  localparam logic [9:0] L_ADC    = 10'(ADC_TMO);

  scan_state_t r_state, w_state_nxt;

  logic [3:0]        r_field, w_field_nxt;
  logic [4:0]        r_cnt, w_cnt_nxt;
  logic              r_dac_req, w_dac_req_nxt;
  logic              r_adc_req, w_adc_req_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
  logic [4*N_RF-1:0] r_shadow, w_shadow_nxt;

  logic       w_run;
  logic       w_abort;
  logic       w_start;
  logic       w_to_err;
  logic       w_to_sample;
  logic       w_ack;
  logic       w_hit;
  logic       w_tmr_clr;
  logic       w_tmr_en;
  logic [9:0] w_limit;
  logic [3:0] w_nib;

  assign w_run   = key_state && (system_state == SYS_SAMPLE);
  assign w_abort = (r_state != S_IDLE) && !w_run;
  assign w_start = (r_state == S_IDLE) && frame_start && w_run;

  assign w_to_err    = (w_state_nxt == S_ERR);
  assign w_to_sample = (r_state == S_SETTLE) && (w_state_nxt == S_SAMPLE);
  assign w_ack       = (r_state == S_SAMPLE) && adc_ack;

  assign w_tmr_clr = (w_state_nxt != r_state);
  assign w_tmr_en  = (r_state == S_DAC_WR) ||
                     (r_state == S_SETTLE) ||
                     (r_state == S_SAMPLE);

  // Select the wait limit for whichever wait state is active.
  always_comb begin
    w_limit = '0;
    unique case (r_state)
      S_DAC_WR: w_limit = L_DAC;
      S_SETTLE: w_limit = L_SET;
      S_SAMPLE: w_limit = L_ADC;
      default:  w_limit = '0;
    endcase
  end

  rf_wait_timer u_tmr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_tmr_clr),
    .i_en    (w_tmr_en),
    .i_limit (w_limit),
    .o_hit   (w_hit)
  );

  // Pick the current position's nibble out of the latched pattern.
  always_comb begin
    w_nib = '0;
    for (int k = 0; k < N_RF; k++) begin
      if (r_cnt == 5'(k)) w_nib = r_shadow[4*k +: 4];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; losing run from any busy state aborts to idle.
  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:   if (w_start) w_state_nxt = S_LOAD;
        S_LOAD:   w_state_nxt = S_DAC_WR;
        S_DAC_WR: begin
          if (dac_done)   w_state_nxt = S_SETTLE;
          else if (w_hit) w_state_nxt = S_ERR;
        end
        S_SETTLE: if (w_hit) w_state_nxt = S_SAMPLE;
        S_SAMPLE: begin
          if (adc_ack)    w_state_nxt = S_NEXT;
          else if (w_hit) w_state_nxt = S_ERR;
        end
        S_NEXT: begin
          if (r_cnt == CNT_LAST) w_state_nxt = S_DONE;
          else                   w_state_nxt = S_LOAD;
        end
        S_DONE:  w_state_nxt = S_IDLE;
        S_ERR:   w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output next values, keyed on the transition being taken.
  always_comb begin
    w_field_nxt   = r_field;
    w_cnt_nxt     = r_cnt;
    w_dac_req_nxt = 1'b0;
    w_adc_req_nxt = r_adc_req;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_err_nxt     = r_err;
    w_shadow_nxt  = r_shadow;
    if (w_abort) begin
      w_cnt_nxt     = CNT_END;
      w_field_nxt   = '0;
      w_adc_req_nxt = 1'b0;
      w_busy_nxt    = 1'b0;
    end else begin
      unique case (1'b1)
        w_start: begin
          w_shadow_nxt = pattern;
          w_err_nxt    = 1'b0;
          w_busy_nxt   = 1'b1;
          w_cnt_nxt    = '0;
        end
        (r_state == S_LOAD): begin
          w_field_nxt   = w_nib;
          w_dac_req_nxt = 1'b1;
        end
        w_to_err: begin
          w_err_nxt     = 1'b1;
          w_cnt_nxt     = CNT_END;
          w_field_nxt   = '0;
          w_adc_req_nxt = 1'b0;
          w_busy_nxt    = 1'b0;
        end
        w_to_sample: w_adc_req_nxt = 1'b1;
        w_ack:       w_adc_req_nxt = 1'b0;
        (r_state == S_NEXT): begin
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt   = CNT_END;
            w_field_nxt = '0;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output and shadow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_field   <= '0;
      r_cnt     <= CNT_END;
      r_dac_req <= 1'b0;
      r_adc_req <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_shadow  <= '0;
    end else begin
      r_field   <= w_field_nxt;
      r_cnt     <= w_cnt_nxt;
      r_dac_req <= w_dac_req_nxt;
      r_adc_req <= w_adc_req_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_shadow  <= w_shadow_nxt;
    end
  end

  assign field     = r_field;
  assign cnt_RF    = r_cnt;
  assign dac_req   = r_dac_req;
  assign adc_req   = r_adc_req;
  assign scan_busy = r_busy;
  assign scan_done = r_done;
  assign err_tmo   = r_err;

endmodule

// File: tb/tb_rf_scan_ctrl.sv
// Directed-plus-random bench for rf_scan_ctrl.
// Expected values come from a position-level model of the scan rules.
module tb_rf_scan_ctrl;

  localparam int N_RF       = 16;
  localparam int SETTLE_CYC = 100;
  localparam int DAC_TMO    = 255;
  localparam int ADC_TMO    = 1023;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              key_state;
  logic [1:0]        system_state;
  logic              frame_start;
  logic [4*N_RF-1:0] pattern;
  logic [3:0]        field;
  logic [4:0]        cnt_RF;
  logic              dac_req;
  logic              dac_done;
  logic              adc_req;
  logic              adc_ack;
  logic              scan_busy;
  logic              scan_done;
  logic              err_tmo;

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;

  rf_scan_ctrl #(
    .N_RF       (N_RF),
    .SETTLE_CYC (SETTLE_CYC),
    .DAC_TMO    (DAC_TMO),
    .ADC_TMO    (ADC_TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_state    (key_state),
    .system_state (system_state),
    .frame_start  (frame_start),
    .pattern      (pattern),
    .field        (field),
    .cnt_RF       (cnt_RF),
    .dac_req      (dac_req),
    .dac_done     (dac_done),
    .adc_req      (adc_req),
    .adc_ack      (adc_ack),
    .scan_busy    (scan_busy),
    .scan_done    (scan_done),
    .err_tmo      (err_tmo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: position k drives nibble k of the frame pattern.
  function automatic logic [3:0] nib(input logic [63:0] p, input int k);
    logic [63:0] s;
    s = p >> (4 * k);
    return s[3:0];
  endfunction

  task automatic start_frame(input logic [63:0] pat);
    pattern = pat;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    pattern = {$urandom, $urandom};
    chk("start_busy", scan_busy, 1);
    chk("start_cnt", cnt_RF, 0);
    chk("start_err", err_tmo, 0);
    chk("start_dacreq", dac_req, 0);
  endtask

  task automatic run_frame(input logic [63:0] pat, input int dd,
                           input int ad, input int abort_pos,
                           input int rst_pos, input bit stray);
    int n, d, a, t_done;
    for (int k = 0; k < N_RF; k++) begin
      n = 0;
      while (dac_req !== 1'b1 && n < 20) begin tick(); n++; end
      chk($sformatf("dac_req_seen[%0d]", k), dac_req, 1);
      if (dac_req !== 1'b1) return;
      chk($sformatf("dac_lat[%0d]", k), n, (k == 0) ? 1 : 2);
      chk($sformatf("field[%0d]", k), field, nib(pat, k));
      chk($sformatf("cnt[%0d]", k), cnt_RF, k);
      if (dd >= 0) d = dd;
      else if (stray) d = $urandom_range(3, 30);
      else d = $urandom_range(0, 30);
      for (int i = 0; i < d; i++) begin
        tick();
        if (stray && i == 0) begin adc_ack = 1'b1; frame_start = 1'b1; end
        if (stray && i == 1) begin adc_ack = 1'b0; frame_start = 1'b0; end
        if (stray && i == 2) begin
          chk("stray_cnt", cnt_RF, k);
          chk("stray_busy", scan_busy, 1);
          chk("stray_adc", adc_req, 0);
        end
      end
      dac_done = 1'b1;
      tick();
      dac_done = 1'b0;
      t_done = cyc;
      chk("dac_req_pulse", dac_req, 0);
      if (k == abort_pos) begin
        repeat (3) tick();
        key_state = 1'b0;
        tick();
        chk("abort_cnt", cnt_RF, N_RF);
        chk("abort_field", field, 0);
        chk("abort_adc", adc_req, 0);
        chk("abort_busy", scan_busy, 0);
        chk("abort_done", scan_done, 0);
        key_state = 1'b1;
        return;
      end
      n = 0;
      while (adc_req !== 1'b1 && n < SETTLE_CYC + 20) begin tick(); n++; end
      chk($sformatf("adc_req_seen[%0d]", k), adc_req, 1);
      if (adc_req !== 1'b1) return;
      chk($sformatf("settle[%0d]", k), cyc - t_done, SETTLE_CYC);
      if (k == rst_pos) begin
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_adc", adc_req, 0);
        chk("rst_cnt", cnt_RF, N_RF);
        chk("rst_field", field, 0);
        chk("rst_busy", scan_busy, 0);
        chk("rst_dac", dac_req, 0);
        chk("rst_done", scan_done, 0);
        chk("rst_err", err_tmo, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_idle_cnt", cnt_RF, N_RF);
        return;
      end
      a = (ad >= 0) ? ad : int'($urandom_range(0, 8));
      for (int i = 0; i < a; i++) tick();
      chk("adc_hold", adc_req, 1);
      adc_ack = 1'b1;
      tick();
      adc_ack = 1'b0;
      chk("adc_drop", adc_req, 0);
    end
    n = 0;
    while (scan_done !== 1'b1 && n < 5) begin tick(); n++; end
    chk("done_seen", scan_done, 1);
    chk("done_lat", n, 1);
    chk("done_busy", scan_busy, 0);
    chk("done_cnt", cnt_RF, N_RF);
    chk("done_field", field, 0);
    chk("done_err", err_tmo, 0);
    tick();
    chk("done_pulse", scan_done, 0);
  endtask

  initial begin
    logic [63:0] p;
    int n, t0;
    bit seen_adc, seen_done;

    rst_n = 1'b1;
    key_state = 1'b1;
    system_state = 2'b01;
    frame_start = 1'b0;
    pattern = '0;
    dac_done = 1'b0;
    adc_ack = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_field", field, 0);
    chk("reset_cnt", cnt_RF, N_RF);
    chk("reset_dac", dac_req, 0);
    chk("reset_adc", adc_req, 0);
    chk("reset_busy", scan_busy, 0);
    chk("reset_done", scan_done, 0);
    chk("reset_err", err_tmo, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    system_state = 2'b11;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    system_state = 2'b01;
    chk("norun_busy", scan_busy, 0);
    chk("norun_cnt", cnt_RF, N_RF);
    key_state = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    key_state = 1'b1;
    chk("nokey_busy", scan_busy, 0);

    p = 64'h0123_4567_89AB_CDEF;
    start_frame(p);
    run_frame(p, 20, 5, -1, -1, 1'b0);

    p = {$urandom, $urandom};
    start_frame(p);
    run_frame(p, -1, -1, -1, -1, 1'b1);

    p = {$urandom, $urandom};
    start_frame(p);
    run_frame(p, 0, 0, -1, -1, 1'b0);

    start_frame({$urandom, $urandom});
    n = 0;
    while (dac_req !== 1'b1 && n < 5) begin tick(); n++; end
    chk("tmo_dacreq", dac_req, 1);
    t0 = cyc;
    seen_adc = 1'b0;
    seen_done = 1'b0;
    n = 0;
    while (err_tmo !== 1'b1 && n < DAC_TMO + 20) begin
      tick();
      n++;
      if (adc_req === 1'b1) seen_adc = 1'b1;
      if (scan_done === 1'b1) seen_done = 1'b1;
    end
    chk("tmo_err", err_tmo, 1);
    chk("tmo_len", cyc - t0, DAC_TMO + 1);
    chk("tmo_no_adc", seen_adc, 0);
    chk("tmo_no_done", seen_done, 0);
    chk("tmo_cnt", cnt_RF, N_RF);
    chk("tmo_field", field, 0);
    chk("tmo_busy", scan_busy, 0);
    repeat (5) tick();
    chk("tmo_sticky", err_tmo, 1);

    p = {$urandom, $urandom};
    start_frame(p);
    run_frame(p, -1, -1, 5, -1, 1'b0);
    repeat (2) tick();

    p = {$urandom, $urandom};
    start_frame(p);
    run_frame(p, -1, -1, -1, -1, 1'b0);

    p = {$urandom, $urandom};
    start_frame(p);
    run_frame(p, -1, -1, -1, 9, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
